// File: rtl/ppu_acc_feeder.sv
// rtl/ppu_acc_feeder.sv - double-buffered accumulator tile feeder for the PPU
// Optional early tile close with zero padding: define PPU_FEED_PAD_EN.
module ppu_acc_feeder #(
    parameter int ACC_W  = 24,
    parameter int VL     = 16,
    parameter int AD     = 16,
    parameter int ADDR_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_acc_valid,
    output logic                  o_acc_ready,
    input  logic [ACC_W*VL-1:0]   i_acc_data,
    input  logic                  i_acc_last,
    input  logic                  i_clear,
    output logic                  o_ppu_start,
    output logic [ACC_W*VL-1:0]   o_ppu_acc_data,
    output logic                  o_busy,
    output logic [ADDR_W-1:0]     o_tiles_sent
);
    localparam int DW    = ACC_W * VL;
    localparam int IDX_W = $clog2(AD);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(AD - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND} state_t;

    state_t              state_q, state_d;
    logic [1:0]          full_q, full_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   tiles_q, tiles_d;
    logic                start_q, start_d;
    logic [DW-1:0]       data_q, data_d;
    logic [DW-1:0]       mem_q [2][AD];

    logic                acc_fire;
    logic                tile_close;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic [DW-1:0]       rd_word;

    assign o_acc_ready = !full_q[wr_bank_q] && !i_clear;
    assign acc_fire    = i_acc_valid && o_acc_ready;
    assign wr_idx      = wr_cnt_q[IDX_W-1:0];
    // Entry prefetched at this edge so the output register holds entry rd_cnt.
    assign rd_idx      = (state_q == S_START) ? '0 : IDX_W'(rd_cnt_q) + IDX_W'(1);

`ifdef PPU_FEED_PAD_EN
    logic [AD-1:0] pad_q [2];
    logic [AD-1:0] pad_d [2];
    logic [AD-1:0] pad_fill;

    assign tile_close = (wr_cnt_q == LAST) || i_acc_last;
    assign pad_fill   = ({AD{1'b1}} << wr_cnt_q) << 1;
    assign rd_word    = pad_q[rd_bank_q][rd_idx] ? '0 : mem_q[rd_bank_q][rd_idx];
`else
    logic unused_last;

    assign unused_last = i_acc_last;
    assign tile_close  = (wr_cnt_q == LAST);
    assign rd_word     = mem_q[rd_bank_q][rd_idx];
`endif

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        tiles_d   = tiles_q;
        start_d   = 1'b0;
        data_d    = '0;
`ifdef PPU_FEED_PAD_EN
        pad_d     = pad_q;
`endif

        if (acc_fire) begin
            if (tile_close) begin
                full_d[wr_bank_q] = 1'b1;
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
`ifdef PPU_FEED_PAD_EN
                pad_d[wr_bank_q]  = pad_fill;
`endif
            end else begin
                wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q] && !i_clear) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end
            end
            S_START: begin
                state_d  = S_SEND;
                rd_cnt_d = '0;
                data_d   = rd_word;
            end
            S_SEND: begin
                if (rd_cnt_q == LAST) begin
                    full_d[rd_bank_q] = 1'b0;
`ifdef PPU_FEED_PAD_EN
                    pad_d[rd_bank_q]  = '0;
`endif
                    rd_bank_d = ~rd_bank_q;
                    rd_cnt_d  = '0;
                    tiles_d   = tiles_q + ADDR_W'(1);
                    // Back-to-back start only if the other bank filled before this cycle.
                    if (full_q[~rd_bank_q] && !i_clear) begin
                        state_d = S_START;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                    data_d   = rd_word;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush keeps the tile in flight; the next fill targets the next bank to drain.
        if (i_clear) begin
            wr_cnt_d = '0;
            if (state_q == S_IDLE) begin
                full_d    = '0;
                wr_bank_d = rd_bank_q;
`ifdef PPU_FEED_PAD_EN
                pad_d[0]  = '0;
                pad_d[1]  = '0;
`endif
            end else begin
                full_d[~rd_bank_q] = 1'b0;
                wr_bank_d          = ~rd_bank_q;
`ifdef PPU_FEED_PAD_EN
                pad_d[~rd_bank_q]  = '0;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            tiles_q   <= '0;
            start_q   <= 1'b0;
            data_q    <= '0;
`ifdef PPU_FEED_PAD_EN
            pad_q[0]  <= '0;
            pad_q[1]  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            tiles_q   <= tiles_d;
            start_q   <= start_d;
            data_q    <= data_d;
`ifdef PPU_FEED_PAD_EN
            pad_q     <= pad_d;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < AD; e++) begin
                    mem_q[b][e] <= '0;
                end
            end
        end else if (acc_fire) begin
            mem_q[wr_bank_q][wr_idx] <= i_acc_data;
        end
    end

    assign o_ppu_start    = start_q;
    assign o_ppu_acc_data = data_q;
    assign o_busy         = (|full_q) || (state_q != S_IDLE);
    assign o_tiles_sent   = tiles_q;

endmodule

// File: tb/tb_ppu_acc_feeder.sv
// tb/tb_ppu_acc_feeder.sv - scoreboard bench for ppu_acc_feeder
module tb_ppu_acc_feeder;
    localparam int ACC_W  = 24;
    localparam int VL     = 16;
    localparam int AD     = 16;
    localparam int ADDR_W = 8;
    localparam int DW     = ACC_W * VL;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              acc_valid = 1'b0;
    logic              acc_ready;
    logic [DW-1:0]     acc_data = '0;
    logic              acc_last = 1'b0;
    logic              clear = 1'b0;
    logic              ppu_start;
    logic [DW-1:0]     ppu_data;
    logic              busy;
    logic [ADDR_W-1:0] tiles_sent;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int win = 0;
    int stalls = 0;
    int last_beat_cyc = 0;
    int exp_q[$];
    int start_hist[$];

    ppu_acc_feeder #(.ACC_W(ACC_W), .VL(VL), .AD(AD), .ADDR_W(ADDR_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_acc_valid    (acc_valid),
        .o_acc_ready    (acc_ready),
        .i_acc_data     (acc_data),
        .i_acc_last     (acc_last),
        .i_clear        (clear),
        .o_ppu_start    (ppu_start),
        .o_ppu_acc_data (ppu_data),
        .o_busy         (busy),
        .o_tiles_sent   (tiles_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected vector per cycle of each start window.
    always @(negedge clk) begin
        int e;
        logic [ACC_W-1:0] lane;
        logic [DW-1:0] ev;
        cyc++;
        if (!rst_n) begin
            while (win > 0) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                win--;
            end
        end else begin
            if (win > 0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL ppu_data: unexpected vector %h at cycle %0d", ppu_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    lane = ACC_W'(e);
                    ev = {VL{lane}};
                    if (ppu_data !== ev) begin
                        fails++;
                        $display("FAIL ppu_data: got %h expected lanes %0h at cycle %0d", ppu_data, lane, cyc);
                    end
                end
                win--;
            end else begin
                tests++;
                if (ppu_data !== '0) begin
                    fails++;
                    $display("FAIL idle_data: got %h expected 0 at cycle %0d", ppu_data, cyc);
                end
            end
            if (ppu_start) begin
                tests++;
                if (win != 0) begin
                    fails++;
                    $display("FAIL start_overlap: start with %0d vectors outstanding, required 0", win);
                end
                start_hist.push_back(cyc);
                win = AD;
            end
        end
    end

    task automatic beat(input int v, input bit last);
        logic [ACC_W-1:0] lv;
        bit r;
        int n;
        lv = ACC_W'(v);
        acc_valid = 1'b1;
        acc_data = {VL{lv}};
        acc_last = last;
        n = 0;
        forever begin
            @(negedge clk);
            r = acc_ready;
            if (!r) stalls++;
            @(posedge clk);
            n++;
            if (r) break;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL beat_timeout: ready=%0d after %0d cycles, required 1", r, n);
                break;
            end
        end
        last_beat_cyc = cyc;
        #1;
    endtask

    task automatic feed(input int base, input int n, input int last_at);
        for (int k = 0; k < n; k++) beat(base + k, (k == last_at));
        acc_valid = 1'b0;
        acc_last = 1'b0;
    endtask

    task automatic expect_tile(input int base, input int nvals);
        for (int k = 0; k < AD; k++) exp_q.push_back((k < nvals) ? base + k : 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            n++;
            if (!busy && win == 0 && exp_q.size() == 0) break;
            if (n > 300) begin
                tests++;
                fails++;
                $display("FAIL %s_idle_timeout: busy=%0d pending=%0d required 0", name, busy, exp_q.size());
                break;
            end
        end
    endtask

    task automatic chk_start(input string name, input int idx, input int exp_cyc);
        tests++;
        if (idx >= start_hist.size()) begin
            fails++;
            $display("FAIL %s: start #%0d missing, required at cycle %0d", name, idx, exp_cyc);
        end else if (start_hist[idx] != exp_cyc) begin
            fails++;
            $display("FAIL %s: start at cycle %0d, required %0d", name, start_hist[idx], exp_cyc);
        end
    endtask

    initial begin
        int b;
        int f1;
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", 64'(ppu_start), 64'd0);
        chk("rst_data", 64'(ppu_data == '0), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tiles", 64'(tiles_sent), 64'd0);
        chk("rst_ready", 64'(acc_ready), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single tile, values 0..15.
        b = start_hist.size();
        feed(0, 16, -1);
        expect_tile(0, 16);
        f1 = last_beat_cyc;
        wait_idle("t1");
        chk_start("t1_start", b, f1 + 2);
        chk("t1_tiles", 64'(tiles_sent), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);

        // Three tiles streamed continuously.
        b = start_hist.size();
        stalls = 0;
        beat(100, 1'b0);
        for (int t = 0; t < 3; t++) begin
            for (int k = (t == 0) ? 1 : 0; k < 16; k++) beat(100 + 16 * t + k, 1'b0);
            expect_tile(100 + 16 * t, 16);
            if (t == 0) f1 = last_beat_cyc;
        end
        acc_valid = 1'b0;
        wait_idle("t2");
        chk_start("t2_start1", b, f1 + 2);
        chk_start("t2_start2", b + 1, f1 + 19);
        chk_start("t2_start3", b + 2, f1 + 36);
        chk("t2_ready_dropped", 64'(stalls > 0), 64'd1);
        chk("t2_tiles", 64'(tiles_sent), 64'd4);

        // Valid gap of five cycles after beat 7.
        b = start_hist.size();
        feed(200, 8, -1);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_early_start", 64'(start_hist.size() - b), 64'd0);
        feed(208, 8, -1);
        expect_tile(200, 16);
        f1 = last_beat_cyc;
        wait_idle("t3");
        chk_start("t3_start", b, f1 + 2);
        chk("t3_tiles", 64'(tiles_sent), 64'd5);

        // Clear during drain of tile A while tile B is half filled.
        b = start_hist.size();
        feed(300, 16, -1);
        expect_tile(300, 16);
        f1 = last_beat_cyc;
        feed(400, 8, -1);
        clear = 1'b1;
        #1;
        chk("t4_ready_in_clear", 64'(acc_ready), 64'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        wait_idle("t4a");
        chk_start("t4_startA", b, f1 + 2);
        chk("t4_one_start", 64'(start_hist.size() - b), 64'd1);
        chk("t4_tilesA", 64'(tiles_sent), 64'd6);
        b = start_hist.size();
        feed(500, 16, -1);
        expect_tile(500, 16);
        f1 = last_beat_cyc;
        wait_idle("t4b");
        chk_start("t4_start_fresh", b, f1 + 2);
        chk("t4_tiles_fresh", 64'(tiles_sent), 64'd7);

`ifdef PPU_FEED_PAD_EN
        // Early close on beat 9, then a normal tile.
        b = start_hist.size();
        feed(0, 10, 9);
        expect_tile(0, 10);
        f1 = last_beat_cyc;
        wait_idle("t5a");
        chk_start("t5_pad_start", b, f1 + 2);
        b = start_hist.size();
        feed(600, 16, -1);
        expect_tile(600, 16);
        f1 = last_beat_cyc;
        wait_idle("t5b");
        chk_start("t5_next_start", b, f1 + 2);
        chk("t5_tiles", 64'(tiles_sent), 64'd9);
`endif

        // Asynchronous reset in the middle of a drain.
        b = start_hist.size();
        feed(700, 16, -1);
        expect_tile(700, 16);
        n = 0;
        while (start_hist.size() == b && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("t6_started", 64'(start_hist.size() - b), 64'd1);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_start", 64'(ppu_start), 64'd0);
        chk("t6_rst_data", 64'(ppu_data == '0), 64'd1);
        chk("t6_rst_ready", 64'(acc_ready), 64'd1);
        chk("t6_rst_tiles", 64'(tiles_sent), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        b = start_hist.size();
        feed(800, 16, -1);
        expect_tile(800, 16);
        f1 = last_beat_cyc;
        wait_idle("t6");
        chk_start("t6_start_after", b, f1 + 2);
        chk("t6_tiles_after", 64'(tiles_sent), 64'd1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
